// File: rtl/ft600_pkg.sv
// Shared types and constants for the FT600 245-synchronous FIFO bus scheduler.
package ft600_pkg;

  localparam int FT_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_OE = 3'd1,
    ST_READ  = 3'd2,
    ST_WR    = 3'd3,
    ST_TURN  = 3'd4
  } ft_state_e;

endpackage

// File: rtl/ft600_skid_fifo.sv
// Small power-of-two FIFO that absorbs read beats arriving from the FT600 while
// the client stream is stalled; supports push and pop on the same edge.
module ft600_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty     = (count_r == CNT_ZERO);
  assign pop_ok_s  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);
  assign rdata     = mem[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_ok_s && !push_ok_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: rtl/ft600_bus_sched.sv
// Shares the FT600 16-bit data bus between the host-to-FPGA read stream and the
// FPGA-to-host write stream, with burst fairness and bus turnaround cycles.
module ft600_bus_sched
  import ft600_pkg::*;
#(
  parameter int MAX_BURST  = 256,
  parameter int SKID_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 usb_rxf,
  input  logic                 usb_txe,
  output logic                 usb_rd_n,
  output logic                 usb_wr_n,
  output logic                 usb_oe_n,
  input  logic [FT_DATA_W-1:0] iov_O,
  output logic [FT_DATA_W-1:0] iov_I,
  output logic                 iov_T,
  output logic                 rx_enq__ENA,
  output logic [FT_DATA_W-1:0] rx_enq_v,
  input  logic                 rx_enq__RDY,
  input  logic                 tx_enq__ENA,
  input  logic [FT_DATA_W-1:0] tx_enq_v,
  output logic                 tx_enq__RDY
);

  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam int FAW = $clog2(SKID_DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_BURST);
  localparam logic [FAW:0]  FIFO_ADMIT = (FAW+1)'(SKID_DEPTH - 3);
  localparam logic [FAW:0]  FIFO_STOP  = (FAW+1)'(SKID_DEPTH - 1);

  ft_state_e              state_r;
  ft_state_e              state_s;
  logic [CW-1:0]          burst_cnt_r;
  logic [CW-1:0]          burst_cnt_s;
  logic                   last_wr_r;
  logic                   last_wr_s;
  logic                   oe_n_r;
  logic                   rd_n_r;
  logic                   wr_n_r;
  logic                   t_r;
  logic [FT_DATA_W-1:0]   dout_r;
  logic [FT_DATA_W-1:0]   dout_s;
  logic                   valid_r;
  logic                   valid_s;

  logic                   capture_s;
  logic                   fifo_pop_s;
  logic                   fifo_empty_s;
  logic [FAW:0]           fifo_cnt_s;
  logic [FAW:0]           fifo_after_s;
  logic                   rd_elig_s;
  logic                   wr_elig_s;
  logic                   tx_rdy_s;
  logic                   tx_acc_s;
  logic                   commit_s;

  ft600_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (FT_DATA_W)
  ) u_skid (
    .clk   (CLK),
    .rst   (RST),
    .push  (capture_s),
    .pop   (fifo_pop_s),
    .wdata (iov_O),
    .rdata (rx_enq_v),
    .count (fifo_cnt_s),
    .empty (fifo_empty_s)
  );

  // rd_n is low only in READ, so a low strobe with data present is a beat.
  assign capture_s    = !rd_n_r && !usb_rxf;
  assign fifo_pop_s   = !fifo_empty_s && rx_enq__RDY;
  assign fifo_after_s = fifo_cnt_s + {{FAW{1'b0}}, capture_s} - {{FAW{1'b0}}, fifo_pop_s};
  assign rd_elig_s    = !usb_rxf && (fifo_cnt_s <= FIFO_ADMIT);
  assign wr_elig_s    = tx_enq__ENA && !usb_txe;

  assign valid_r  = !wr_n_r;
  assign tx_rdy_s = (state_r == ST_WR) && (!valid_r || !usb_txe) && (burst_cnt_r < CNT_MAX);
  assign tx_acc_s = tx_enq__ENA && tx_rdy_s;
  assign commit_s = valid_r && !usb_txe;

  assign rx_enq__ENA = fifo_pop_s;
  assign tx_enq__RDY = tx_rdy_s;
  assign usb_oe_n    = oe_n_r;
  assign usb_rd_n    = rd_n_r;
  assign usb_wr_n    = wr_n_r;
  assign iov_T       = t_r;
  assign iov_I       = dout_r;

  // Arbitration and burst-termination decisions.
  always_comb begin
    state_s     = state_r;
    burst_cnt_s = burst_cnt_r;
    last_wr_s   = last_wr_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_elig_s && wr_elig_s) begin
          state_s = last_wr_r ? ST_RD_OE : ST_WR;
        end else if (rd_elig_s) begin
          state_s = ST_RD_OE;
        end else if (wr_elig_s) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_OE: begin
        state_s = ST_READ;
      end
      ST_READ: begin
        if (capture_s) begin
          burst_cnt_s = burst_cnt_r + CNT_ONE;
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
        if (usb_rxf || (fifo_after_s >= FIFO_STOP) || (burst_cnt_s == CNT_MAX)) begin
          state_s   = ST_TURN;
          last_wr_s = 1'b0;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_WR: begin
        if (tx_acc_s) begin
          burst_cnt_s = burst_cnt_r + CNT_ONE;
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
        // An accepted beat always stays in WR until it has been committed.
        if (!valid_r && !tx_acc_s &&
            (!tx_enq__ENA || (burst_cnt_r == CNT_MAX) || usb_txe)) begin
          state_s   = ST_TURN;
          last_wr_s = 1'b1;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_TURN: begin
        state_s     = ST_IDLE;
        burst_cnt_s = '0;
      end
      default: begin
        state_s     = ST_IDLE;
        burst_cnt_s = '0;
        last_wr_s   = 1'b0;
      end
    endcase
  end

  // Write beat register: load on accept, drop on commit, otherwise hold.
  always_comb begin
    valid_s = valid_r;
    dout_s  = dout_r;
    if (tx_acc_s) begin
      valid_s = 1'b1;
      dout_s  = tx_enq_v;
    end else if (commit_s) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // Pin strobes are decoded from the next state so they change with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      burst_cnt_r <= '0;
      last_wr_r   <= 1'b0;
      oe_n_r      <= 1'b1;
      rd_n_r      <= 1'b1;
      wr_n_r      <= 1'b1;
      t_r         <= 1'b1;
      dout_r      <= '0;
    end else begin
      state_r     <= state_s;
      burst_cnt_r <= burst_cnt_s;
      last_wr_r   <= last_wr_s;
      oe_n_r      <= !((state_s == ST_RD_OE) || (state_s == ST_READ));
      rd_n_r      <= (state_s != ST_READ);
      wr_n_r      <= !valid_s;
      t_r         <= (state_s != ST_WR);
      dout_r      <= dout_s;
    end
  end

endmodule

// File: tb/tb_ft600_bus_sched.sv
// Scoreboard bench: an FT600 pin model feeds read words and swallows write
// words; expected data is queued at stimulus time and popped at DUT output.
module tb_ft600_bus_sched;

  localparam int MB = 16;
  localparam int SD = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        usb_rxf, usb_txe, usb_rd_n, usb_wr_n, usb_oe_n;
  logic [15:0] iov_O, iov_I;
  logic        iov_T;
  logic        rx_ena, rx_rdy;
  logic [15:0] rx_v;
  logic        tx_ena, tx_rdy;
  logic [15:0] tx_v;

  ft600_bus_sched #(.MAX_BURST(MB), .SKID_DEPTH(SD)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .usb_rxf     (usb_rxf),
    .usb_txe     (usb_txe),
    .usb_rd_n    (usb_rd_n),
    .usb_wr_n    (usb_wr_n),
    .usb_oe_n    (usb_oe_n),
    .iov_O       (iov_O),
    .iov_I       (iov_I),
    .iov_T       (iov_T),
    .rx_enq__ENA (rx_ena),
    .rx_enq_v    (rx_v),
    .rx_enq__RDY (rx_rdy),
    .tx_enq__ENA (tx_ena),
    .tx_enq_v    (tx_v),
    .tx_enq__RDY (tx_rdy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc, n_cap, n_pop, n_commit;
  int first_oe, first_rd, first_pop, first_acc, first_wr;
  int idle_run, last_dir, stall_at, stall_left;
  bit stall_armed, txe_force, rx_rdy_q;
  logic [15:0] host_q[$];
  logic [15:0] tx_src[$];
  logic [15:0] exp_rx[$];
  logic [15:0] exp_tx[$];
  bit          beat_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_counters();
    cyc = 0; n_cap = 0; n_pop = 0; n_commit = 0;
    first_oe = -1; first_rd = -1; first_pop = -1; first_acc = -1; first_wr = -1;
    idle_run = 0; last_dir = 0; stall_left = 0; stall_armed = 1'b0;
    beat_log.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    host_q.delete(); tx_src.delete(); exp_rx.delete(); exp_tx.delete();
    usb_rxf = 1'b1; usb_txe = 1'b0; iov_O = 16'h0000;
    tx_ena = 1'b0; tx_v = 16'h0000; rx_rdy = 1'b0; rx_rdy_q = 1'b0; txe_force = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    reset_counters();
  endtask

  // One bus cycle: drive the FT600/stream side at negedge, then predict and
  // score what the following posedge will do.
  task automatic step();
    int cur;
    @(negedge CLK);
    if (stall_armed && (n_commit == stall_at)) begin
      stall_left  = 3;
      stall_armed = 1'b0;
    end
    usb_rxf = (host_q.size() == 0);
    if (host_q.size() != 0) iov_O = host_q[0]; else iov_O = 16'h0000;
    usb_txe = txe_force || (stall_left > 0);
    tx_ena  = (tx_src.size() != 0);
    if (tx_src.size() != 0) tx_v = tx_src[0]; else tx_v = 16'h0000;
    rx_rdy  = rx_rdy_q;
    #1;
    if (!usb_oe_n && first_oe < 0) first_oe = cyc;
    if (!usb_rd_n && first_rd < 0) first_rd = cyc;
    if (!usb_wr_n && first_wr < 0) first_wr = cyc;
    if (!usb_oe_n) check_eq("oe_vs_T", iov_T, 1'b1);
    if (!usb_wr_n) check_eq("wr_vs_T", iov_T, 1'b0);
    cur = !usb_oe_n ? 1 : (!iov_T ? 2 : 0);
    if (cur == 0) begin
      idle_run++;
    end else begin
      if (last_dir != 0 && cur != last_dir) check_eq("turn_gap", (idle_run >= 2), 1'b1);
      last_dir = cur;
      idle_run = 0;
    end
    if (!usb_rd_n && !usb_rxf) begin
      exp_rx.push_back(host_q.pop_front());
      beat_log.push_back(1'b0);
      n_cap++;
    end
    if (rx_ena) begin
      if (first_pop < 0) first_pop = cyc;
      if (exp_rx.size() == 0) check_eq("rx_spurious", rx_ena, 1'b0);
      else check_eq("rx_data", rx_v, exp_rx.pop_front());
      n_pop++;
    end
    if (stall_left > 0) begin
      check_eq("stall_wr_n", usb_wr_n, 1'b0);
      check_eq("stall_rdy", tx_rdy, 1'b0);
      if (exp_tx.size() != 0) check_eq("stall_data", iov_I, exp_tx[0]);
      stall_left--;
    end
    if (!usb_wr_n && !usb_txe) begin
      if (exp_tx.size() == 0) check_eq("tx_spurious", usb_wr_n, 1'b1);
      else check_eq("tx_data", iov_I, exp_tx.pop_front());
      beat_log.push_back(1'b1);
      n_commit++;
    end
    if (tx_ena && tx_rdy) begin
      if (first_acc < 0) first_acc = cyc;
      exp_tx.push_back(tx_src.pop_front());
    end
    cyc++;
  endtask

  initial begin
    int run_len[$];
    bit run_dir[$];
    bit exp_dir;

    // Reset state while RST is held.
    RST = 1'b1;
    usb_rxf = 1'b1; usb_txe = 1'b0; iov_O = 16'h0000;
    tx_ena = 1'b0; tx_v = 16'h0000; rx_rdy = 1'b0; rx_rdy_q = 1'b0; txe_force = 1'b0;
    reset_counters();
    repeat (3) @(negedge CLK);
    check_eq("rst_rd_n", usb_rd_n, 1'b1);
    check_eq("rst_wr_n", usb_wr_n, 1'b1);
    check_eq("rst_oe_n", usb_oe_n, 1'b1);
    check_eq("rst_T", iov_T, 1'b1);
    check_eq("rst_I", iov_I, 16'h0000);
    check_eq("rst_rx_ena", rx_ena, 1'b0);
    check_eq("rst_tx_rdy", tx_rdy, 1'b0);

    // Ten-beat read burst with a ready client.
    do_reset();
    for (int i = 0; i < 10; i++) host_q.push_back(16'hA000 + 16'(i * 3));
    rx_rdy_q = 1'b1;
    repeat (25) step();
    check_eq("rd10_captures", n_cap, 10);
    check_eq("rd10_delivered", n_pop, 10);
    check_eq("rd10_oe_latency", first_oe, 1);
    check_eq("rd10_rd_latency", first_rd, 2);
    check_eq("rd10_ena_latency", first_pop, 3);
    check_eq("rd10_left", exp_rx.size(), 0);
    check_eq("rd10_rd_n_end", usb_rd_n, 1'b1);
    check_eq("rd10_oe_n_end", usb_oe_n, 1'b1);

    // Client back-pressure: reading stops short of overflowing the skid FIFO.
    do_reset();
    for (int i = 0; i < 8; i++) host_q.push_back(16'h3C00 + 16'(i));
    repeat (20) step();
    check_eq("bp_captures", n_cap, SD - 1);
    check_eq("bp_rd_n_high", usb_rd_n, 1'b1);
    check_eq("bp_no_pop", n_pop, 0);
    rx_rdy_q = 1'b1;
    repeat (60) step();
    check_eq("bp_delivered", n_pop, 8);
    check_eq("bp_host_drained", host_q.size(), 0);
    check_eq("bp_left", exp_rx.size(), 0);

    // Five write beats; the FT600 reports full for 3 cycles on beat 3.
    do_reset();
    for (int i = 0; i < 5; i++) tx_src.push_back(16'h5A50 + 16'(i));
    stall_at = 2;
    stall_armed = 1'b1;
    repeat (25) step();
    check_eq("wr_committed", n_commit, 5);
    check_eq("wr_left", exp_tx.size(), 0);
    check_eq("wr_accept_cycle", first_acc, 1);
    check_eq("wr_strobe_latency", first_wr, first_acc + 1);
    check_eq("wr_T_end", iov_T, 1'b1);

    // Both sides busy: write first, then bursts of MB beats alternate.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      host_q.push_back(16'h1000 + 16'(i));
      tx_src.push_back(16'h2000 + 16'(i));
    end
    rx_rdy_q = 1'b1;
    repeat (70) step();
    host_q.delete();
    tx_src.delete();
    repeat (30) step();
    check_eq("fair_rx_left", exp_rx.size(), 0);
    check_eq("fair_tx_left", exp_tx.size(), 0);
    foreach (beat_log[i]) begin
      if (i == 0 || beat_log[i] != beat_log[i-1]) begin
        run_dir.push_back(beat_log[i]);
        run_len.push_back(1);
      end else begin
        run_len[run_len.size()-1]++;
      end
    end
    check_eq("fair_run_count", (run_len.size() >= 3), 1'b1);
    exp_dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (run_len.size() > i) begin
        check_eq("fair_dir", run_dir[i], exp_dir);
        check_eq("fair_len", run_len[i], MB);
      end
      exp_dir = !exp_dir;
    end

    // Asynchronous reset in the middle of a read burst with 2 words buffered.
    do_reset();
    for (int i = 0; i < 8; i++) host_q.push_back(16'h7700 + 16'(i));
    for (int i = 0; i < 20 && n_cap < 2; i++) step();
    check_eq("mid_rst_setup", n_cap, 2);
    @(posedge CLK);
    #2;
    check_eq("mid_rst_pre_rd_n", usb_rd_n, 1'b0);
    RST = 1'b1;
    #1;
    check_eq("mid_rst_rd_n", usb_rd_n, 1'b1);
    check_eq("mid_rst_oe_n", usb_oe_n, 1'b1);
    check_eq("mid_rst_wr_n", usb_wr_n, 1'b1);
    check_eq("mid_rst_T", iov_T, 1'b1);
    check_eq("mid_rst_tx_rdy", tx_rdy, 1'b0);
    host_q.delete();
    exp_rx.delete();
    #1;
    RST = 1'b0;
    rx_rdy_q = 1'b1;
    step();
    check_eq("mid_rst_rx_ena", rx_ena, 1'b0);
    repeat (3) step();

    // Write request while the FT600 has no space and no read data.
    do_reset();
    txe_force = 1'b1;
    tx_src.push_back(16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("txe_block_rdy", tx_rdy, 1'b0);
      check_eq("txe_block_T", iov_T, 1'b1);
    end
    txe_force = 1'b0;
    step();
    step();
    check_eq("txe_release_T", iov_T, 1'b0);
    repeat (6) step();
    check_eq("txe_release_commit", n_commit, 1);
    check_eq("txe_release_left", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
